// File: rtl/fifo_mem_mc_if.sv
// Bus bundle for the multi-channel FIFO storage array: write port, read port,
// per-channel full/empty flags and registered read results.
interface fifo_mem_mc_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4,
  parameter int CH_NUM    = 2
);
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                   wr_en;
  logic [CHW-1:0]         wr_ch;
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [DATA_SIZE-1:0]   wr_data;
  logic [DATA_SIZE/8-1:0] wr_be;
  logic [CH_NUM-1:0]      fifo_full;
  logic                   rd_en;
  logic [CHW-1:0]         rd_ch;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [CH_NUM-1:0]      fifo_empty;
  logic [DATA_SIZE-1:0]   rd_data;
  logic                   rd_valid;
  logic [CHW-1:0]         rd_ch_out;
  logic                   rd_par_err;

  modport master (
    output wr_en, wr_ch, wr_addr, wr_data, wr_be, fifo_full,
    output rd_en, rd_ch, rd_addr, fifo_empty,
    input  rd_data, rd_valid, rd_ch_out, rd_par_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_addr, wr_data, wr_be, fifo_full,
    input  rd_en, rd_ch, rd_addr, fifo_empty,
    output rd_data, rd_valid, rd_ch_out, rd_par_err
  );
endinterface

// File: rtl/fifo_mem_mc.sv
// Dual-clock storage array shared by CH_NUM FIFO channels, byte-enabled writes,
// pipelined reads (RD_LAT 1 or 2). Optional per-byte parity: FIFO_MEM_MC_PARITY_EN.
module fifo_mem_mc #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4,
  parameter int CH_NUM    = 2,
  parameter int RD_LAT    = 1
) (
  input logic          wclk,
  input logic          rclk,
  input logic          rst_n,
  fifo_mem_mc_if.slave bus
);
  localparam int CHW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int WORDS = CH_NUM * DEPTH;
  localparam int BYTES = DATA_SIZE / 8;
  localparam int IDXW  = CHW + ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [WORDS];

  // DEPTH is a power of two, so {ch, addr} equals ch*DEPTH + addr
  logic [IDXW-1:0] wrIdx;
  logic [IDXW-1:0] rdIdx;
  logic            wrAccept;
  logic            rdAccept;

  assign wrIdx    = {bus.wr_ch, bus.wr_addr};
  assign rdIdx    = {bus.rd_ch, bus.rd_addr};
  assign wrAccept = bus.wr_en && (32'(bus.wr_ch) < 32'(CH_NUM)) && !bus.fifo_full[bus.wr_ch];
  assign rdAccept = bus.rd_en && (32'(bus.rd_ch) < 32'(CH_NUM)) && !bus.fifo_empty[bus.rd_ch];

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else if (wrAccept) begin
      for (int k = 0; k < BYTES; k++) begin
        if (bus.wr_be[k]) begin
          mem_q[wrIdx][8*k +: 8] <= bus.wr_data[8*k +: 8];
        end
      end
    end
  end

`ifdef FIFO_MEM_MC_PARITY_EN
  logic [BYTES-1:0] parMem_q [WORDS];
  logic [BYTES-1:0] rdParCalc;
  logic             rdParErr;

  // Parity only changes for enabled bytes; disabled bytes keep both data and parity
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        parMem_q[w] <= '0;
      end
    end else if (wrAccept) begin
      for (int k = 0; k < BYTES; k++) begin
        if (bus.wr_be[k]) begin
          parMem_q[wrIdx][k] <= ^bus.wr_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    rdParCalc = '0;
    for (int k = 0; k < BYTES; k++) begin
      rdParCalc[k] = ^mem_q[rdIdx][8*k +: 8];
    end
  end

  assign rdParErr = |(rdParCalc ^ parMem_q[rdIdx]);
`endif

  logic                 s1Valid_q;
  logic [DATA_SIZE-1:0] s1Data_q;
  logic [DATA_SIZE-1:0] s1Data_d;
  logic [CHW-1:0]       s1Ch_q;
  logic [CHW-1:0]       s1Ch_d;
`ifdef FIFO_MEM_MC_PARITY_EN
  logic                 s1Err_q;
  logic                 s1Err_d;
`endif

  // First read stage captures only on an accepted read so idle cycles hold the last result
  always_comb begin
    s1Data_d = s1Data_q;
    s1Ch_d   = s1Ch_q;
`ifdef FIFO_MEM_MC_PARITY_EN
    s1Err_d  = s1Err_q;
`endif
    if (rdAccept) begin
      s1Data_d = mem_q[rdIdx];
      s1Ch_d   = bus.rd_ch;
`ifdef FIFO_MEM_MC_PARITY_EN
      s1Err_d  = rdParErr;
`endif
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Ch_q    <= '0;
`ifdef FIFO_MEM_MC_PARITY_EN
      s1Err_q   <= 1'b0;
`endif
    end else begin
      s1Valid_q <= rdAccept;
      s1Data_q  <= s1Data_d;
      s1Ch_q    <= s1Ch_d;
`ifdef FIFO_MEM_MC_PARITY_EN
      s1Err_q   <= s1Err_d;
`endif
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                 s2Valid_q;
    logic [DATA_SIZE-1:0] s2Data_q;
    logic [DATA_SIZE-1:0] s2Data_d;
    logic [CHW-1:0]       s2Ch_q;
    logic [CHW-1:0]       s2Ch_d;
`ifdef FIFO_MEM_MC_PARITY_EN
    logic                 s2Err_q;
    logic                 s2Err_d;
`endif

    always_comb begin
      s2Data_d = s2Data_q;
      s2Ch_d   = s2Ch_q;
`ifdef FIFO_MEM_MC_PARITY_EN
      s2Err_d  = s2Err_q;
`endif
      if (s1Valid_q) begin
        s2Data_d = s1Data_q;
        s2Ch_d   = s1Ch_q;
`ifdef FIFO_MEM_MC_PARITY_EN
        s2Err_d  = s1Err_q;
`endif
      end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
        s2Valid_q <= 1'b0;
        s2Data_q  <= '0;
        s2Ch_q    <= '0;
`ifdef FIFO_MEM_MC_PARITY_EN
        s2Err_q   <= 1'b0;
`endif
      end else begin
        s2Valid_q <= s1Valid_q;
        s2Data_q  <= s2Data_d;
        s2Ch_q    <= s2Ch_d;
`ifdef FIFO_MEM_MC_PARITY_EN
        s2Err_q   <= s2Err_d;
`endif
      end
    end

    assign bus.rd_valid  = s2Valid_q;
    assign bus.rd_data   = s2Data_q;
    assign bus.rd_ch_out = s2Ch_q;
`ifdef FIFO_MEM_MC_PARITY_EN
    assign bus.rd_par_err = s2Err_q & s2Valid_q;
`else
    assign bus.rd_par_err = 1'b0;
`endif
  end else begin : g_lat1
    assign bus.rd_valid  = s1Valid_q;
    assign bus.rd_data   = s1Data_q;
    assign bus.rd_ch_out = s1Ch_q;
`ifdef FIFO_MEM_MC_PARITY_EN
    assign bus.rd_par_err = s1Err_q & s1Valid_q;
`else
    assign bus.rd_par_err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_fifo_mem_mc.sv
// Scoreboard bench for fifo_mem_mc: one DUT per read latency (1 and 2) driven
// with identical directed stimulus; monitors pop expected results on rd_valid.
module tb_fifo_mem_mc;
  localparam int DS = 16;
  localparam int AS = 4;
  localparam int CN = 2;

  typedef struct {
    logic [15:0] data;
    logic        ch;
    logic        perr;
    int          due;
  } exp_t;

  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic rst_n;
  int   rcyc   = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qA[$];
  exp_t qB[$];

  always #5 wclk = ~wclk;
  always #6 rclk = ~rclk;

  always @(posedge rclk) rcyc = rcyc + 1;

  fifo_mem_mc_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .CH_NUM(CN)) busA ();
  fifo_mem_mc_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .CH_NUM(CN)) busB ();

  fifo_mem_mc #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .CH_NUM(CN), .RD_LAT(1)) dutA (
    .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .bus(busA)
  );
  fifo_mem_mc #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .CH_NUM(CN), .RD_LAT(2)) dutB (
    .wclk(wclk), .rclk(rclk), .rst_n(rst_n), .bus(busB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the latency-1 DUT: each rd_valid must match the oldest expectation on its due cycle
  always @(negedge rclk) begin : monA
    exp_t e;
    if (busA.rd_valid === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("lat1 unexpected rd_valid", 32'd1, 32'd0);
      end else begin
        e = qA.pop_front();
        checkOutput("lat1 rd_data", 32'(busA.rd_data), 32'(e.data));
        checkOutput("lat1 rd_ch_out", 32'(busA.rd_ch_out), 32'(e.ch));
        checkOutput("lat1 rd_par_err", 32'(busA.rd_par_err), 32'(e.perr));
        checkOutput("lat1 arrival cycle", 32'(rcyc), 32'(e.due));
      end
    end else if (qA.size() != 0 && qA[0].due <= rcyc) begin
      checkOutput("lat1 missing rd_valid", 32'd0, 32'd1);
      e = qA.pop_front();
    end
  end

  // Monitor for the latency-2 DUT
  always @(negedge rclk) begin : monB
    exp_t e;
    if (busB.rd_valid === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("lat2 unexpected rd_valid", 32'd1, 32'd0);
      end else begin
        e = qB.pop_front();
        checkOutput("lat2 rd_data", 32'(busB.rd_data), 32'(e.data));
        checkOutput("lat2 rd_ch_out", 32'(busB.rd_ch_out), 32'(e.ch));
        checkOutput("lat2 rd_par_err", 32'(busB.rd_par_err), 32'(e.perr));
        checkOutput("lat2 arrival cycle", 32'(rcyc), 32'(e.due));
      end
    end else if (qB.size() != 0 && qB[0].due <= rcyc) begin
      checkOutput("lat2 missing rd_valid", 32'd0, 32'd1);
      e = qB.pop_front();
    end
  end

  task automatic applyWrite(input int ch, input int addr, input logic [15:0] data, input logic [1:0] be);
    @(negedge wclk);
    busA.wr_en = 1'b1;     busB.wr_en = 1'b1;
    busA.wr_ch = 1'(ch);   busB.wr_ch = 1'(ch);
    busA.wr_addr = 4'(addr); busB.wr_addr = 4'(addr);
    busA.wr_data = data;   busB.wr_data = data;
    busA.wr_be = be;       busB.wr_be = be;
    @(negedge wclk);
    busA.wr_en = 1'b0;     busB.wr_en = 1'b0;
  endtask

  task automatic applyRead(input int ch, input int addr, input logic [15:0] data, input bit accept, input bit perr);
    exp_t e;
    @(negedge rclk);
    busA.rd_en = 1'b1;       busB.rd_en = 1'b1;
    busA.rd_ch = 1'(ch);     busB.rd_ch = 1'(ch);
    busA.rd_addr = 4'(addr); busB.rd_addr = 4'(addr);
    if (accept) begin
      e.data = data;
      e.ch   = 1'(ch);
      e.perr = perr;
      e.due  = rcyc + 1;
      qA.push_back(e);
      e.due  = rcyc + 2;
      qB.push_back(e);
    end
  endtask

  task automatic readIdle(input int n);
    repeat (n) begin
      @(negedge rclk);
      busA.rd_en = 1'b0; busB.rd_en = 1'b0;
    end
  endtask

  task automatic setFlags(input logic [1:0] full, input logic [1:0] empty);
    busA.fifo_full = full;   busB.fifo_full = full;
    busA.fifo_empty = empty; busB.fifo_empty = empty;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " lat1 rd_data"}, 32'(busA.rd_data), 32'd0);
    checkOutput({tag, " lat1 rd_valid"}, 32'(busA.rd_valid), 32'd0);
    checkOutput({tag, " lat1 rd_ch_out"}, 32'(busA.rd_ch_out), 32'd0);
    checkOutput({tag, " lat1 rd_par_err"}, 32'(busA.rd_par_err), 32'd0);
    checkOutput({tag, " lat2 rd_data"}, 32'(busB.rd_data), 32'd0);
    checkOutput({tag, " lat2 rd_valid"}, 32'(busB.rd_valid), 32'd0);
    checkOutput({tag, " lat2 rd_ch_out"}, 32'(busB.rd_ch_out), 32'd0);
    checkOutput({tag, " lat2 rd_par_err"}, 32'(busB.rd_par_err), 32'd0);
  endtask

  task automatic applyStimulus();
    rst_n = 1'b0;
    busA.wr_en = 1'b0; busB.wr_en = 1'b0;
    busA.wr_ch = '0;   busB.wr_ch = '0;
    busA.wr_addr = '0; busB.wr_addr = '0;
    busA.wr_data = '0; busB.wr_data = '0;
    busA.wr_be = '0;   busB.wr_be = '0;
    busA.rd_en = 1'b0; busB.rd_en = 1'b0;
    busA.rd_ch = '0;   busB.rd_ch = '0;
    busA.rd_addr = '0; busB.rd_addr = '0;
    setFlags(2'b00, 2'b00);
    repeat (3) @(negedge wclk);
    checkCleared("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge wclk);

    // Basic full-word write and read
    applyWrite(0, 3, 16'hA5C3, 2'b11);
    applyRead(0, 3, 16'hA5C3, 1'b1, 1'b0);
    readIdle(4);

    // Byte-enable merge, neighbouring channel untouched, zero-enable write is a no-op
    applyWrite(1, 3, 16'h1234, 2'b11);
    applyWrite(1, 3, 16'hFFFF, 2'b01);
    applyRead(1, 3, 16'h12FF, 1'b1, 1'b0);
    readIdle(1);
    applyRead(0, 3, 16'hA5C3, 1'b1, 1'b0);
    readIdle(4);
    applyWrite(1, 3, 16'h0000, 2'b00);
    applyWrite(0, 6, 16'hFF00, 2'b11);
    applyWrite(0, 6, 16'h0001, 2'b01);
    applyRead(1, 3, 16'h12FF, 1'b1, 1'b0);
    readIdle(1);
    applyRead(0, 6, 16'hFF01, 1'b1, 1'b0);
    readIdle(4);

    // Full flag blocks only its own channel
    setFlags(2'b01, 2'b00);
    applyWrite(0, 0, 16'hDEAD, 2'b11);
    applyWrite(1, 0, 16'hBEEF, 2'b11);
    setFlags(2'b10, 2'b00);
    applyWrite(0, 1, 16'h0777, 2'b11);
    setFlags(2'b00, 2'b00);
    applyRead(0, 0, 16'h0000, 1'b1, 1'b0);
    readIdle(1);
    applyRead(1, 0, 16'hBEEF, 1'b1, 1'b0);
    readIdle(1);
    applyRead(0, 1, 16'h0777, 1'b1, 1'b0);
    readIdle(4);

    // Empty flag suppresses reads only on its own channel
    setFlags(2'b00, 2'b10);
    applyRead(1, 0, 16'hBEEF, 1'b0, 1'b0);
    readIdle(1);
    applyRead(0, 3, 16'hA5C3, 1'b1, 1'b0);
    readIdle(4);
    setFlags(2'b00, 2'b00);

    // Back-to-back burst: one result per cycle, in order, then outputs hold
    for (int i = 0; i < 4; i++) applyWrite(1, i, 16'(16'h0010 + i), 2'b11);
    for (int i = 0; i < 4; i++) applyRead(1, i, 16'(16'h0010 + i), 1'b1, 1'b0);
    readIdle(4);
    checkOutput("lat1 hold rd_data", 32'(busA.rd_data), 32'h0013);
    checkOutput("lat2 hold rd_data", 32'(busB.rd_data), 32'h0013);
    checkOutput("lat1 hold rd_ch_out", 32'(busA.rd_ch_out), 32'd1);
    checkOutput("lat2 hold rd_valid", 32'(busB.rd_valid), 32'd0);
    checkOutput("queues drained after burst", 32'(qA.size() + qB.size()), 32'd0);

    // Reset in the middle of a burst discards in-flight reads and clears the array
    applyRead(1, 0, 16'h0010, 1'b1, 1'b0);
    applyRead(1, 1, 16'h0011, 1'b1, 1'b0);
    @(posedge rclk);
    #3;
    rst_n = 1'b0;
    busA.rd_en = 1'b0; busB.rd_en = 1'b0;
    qA.delete();
    qB.delete();
    #1;
    checkCleared("mid-burst reset");
    repeat (3) @(negedge wclk);
    rst_n = 1'b1;
    repeat (2) @(negedge wclk);
    applyRead(0, 3, 16'h0000, 1'b1, 1'b0);
    readIdle(1);
    applyRead(1, 3, 16'h0000, 1'b1, 1'b0);
    readIdle(1);
    applyRead(1, 2, 16'h0000, 1'b1, 1'b0);
    readIdle(1);
    applyRead(0, 1, 16'h0000, 1'b1, 1'b0);
    readIdle(4);

`ifdef FIFO_MEM_MC_PARITY_EN
    // Corrupt one stored parity bit; only that word reports an error
    applyWrite(1, 5, 16'h5A3C, 2'b11);
    applyWrite(0, 5, 16'h0F0E, 2'b11);
    dutA.parMem_q[21][0] = ~dutA.parMem_q[21][0];
    dutB.parMem_q[21][0] = ~dutB.parMem_q[21][0];
    applyRead(1, 5, 16'h5A3C, 1'b1, 1'b1);
    readIdle(1);
    applyRead(0, 5, 16'h0F0E, 1'b1, 1'b0);
    readIdle(4);
`endif

    checkOutput("queues drained at end", 32'(qA.size() + qB.size()), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
